ioctl_loader: RTL

Receiving end of the HPS ioctl download port. Accepts 16-bit ioctl write pulses, maps them by `ioctl_index` into a memory region (ROM BIOS or RAM image), buffers them in a 2-entry FIFO, and issues them as word writes to the SDRAM memory interface. It back-pressures the writer with `ioctl_wait` and reports completion and errors to core control. It sits in `pcfx_top` between the ioctl bus and `memif_sdram`.

---
 rtl/core_pkg.sv | 37 +++
 rtl/ioctl_loader_fifo.sv | 58 +++++
 rtl/ioctl_loader.sv | 129 ++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the ioctl download path.
// Holds the region enum, loader state enum, FIFO entry struct, default
// region map, and the index-to-region decode helper.
package core_pkg;

  localparam logic [24:0] ROM_BASE_A = 25'h000_0000;
  localparam logic [24:0] ROM_SIZE   = 25'h010_0000;
  localparam logic [24:0] RAM_BASE_A = 25'h100_0000;
  localparam logic [24:0] RAM_SIZE   = 25'h020_0000;

  typedef enum logic [1:0] {
    REGION_ROM,
    REGION_RAM,
    REGION_NONE
  } load_region_t;

  typedef enum logic [1:0] {
    LOAD_IDLE,
    LOAD_ACTIVE,
    LOAD_DRAIN
  } load_state_t;

  typedef struct packed {
    logic [24:0] a;
    logic [15:0] d;
  } load_wr_t;

  // Region code carried in ioctl_index[5:0].
  function automatic load_region_t decode_region(input logic [5:0] code);
    case (code)
      6'd0:    return REGION_ROM;
      6'd1:    return REGION_RAM;
      default: return REGION_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ioctl_loader_fifo.sv
// ioctl_loader_fifo: 2-entry FIFO of load_wr_t. Slot 0 is always the head,
// so the head can drive the memory bus straight from a register.
module ioctl_loader_fifo
  import core_pkg::*;
(
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       push,
  input  load_wr_t   push_data,
  input  logic       pop,
  output load_wr_t   head,
  output logic [1:0] count,
  output logic       full
);

  load_wr_t   slot [2];
  logic [1:0] valid;

  assign head  = slot[0];
  assign full  = valid[1];
  assign count = {valid[1], valid[0] & ~valid[1]};

  // Shift-style storage: pop moves slot 1 into slot 0, push fills the first free slot.
  // NOTE: with only two entries the data slots are reset as well, so the memory bus reads 0 out of reset.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      slot[0] <= '0;
      slot[1] <= '0;
      valid   <= 2'b00;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (!valid[0]) begin
            slot[0]  <= push_data;
            valid[0] <= 1'b1;
          end else if (!valid[1]) begin
            slot[1]  <= push_data;
            valid[1] <= 1'b1;
          end
        end
        2'b01: begin
          slot[0] <= slot[1];
          valid   <= {1'b0, valid[1]};
        end
        2'b11: begin
          if (valid[1]) begin
            slot[0] <= slot[1];
            slot[1] <= push_data;
          end else begin
            slot[0] <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ioctl_loader.sv
// ioctl_loader: receives ioctl download writes, maps them into the ROM or RAM
// region chosen by ioctl_index at session start, queues them in a 2-entry
// FIFO and issues them as SDRAM word writes.
// Optional feature macro: IOCTL_LOADER_CKSUM_EN (running word sum on load_cksum).
module ioctl_loader #(
  parameter logic [24:0] ROM_BASE_A = core_pkg::ROM_BASE_A,
  parameter logic [24:0] ROM_SIZE   = core_pkg::ROM_SIZE,
  parameter logic [24:0] RAM_BASE_A = core_pkg::RAM_BASE_A,
  parameter logic [24:0] RAM_SIZE   = core_pkg::RAM_SIZE
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [15:0] ioctl_dout,
  output logic        ioctl_wait,
  output logic        mem_req,
  output logic [24:0] mem_a,
  output logic [15:0] mem_d,
  input  logic        mem_ack,
  output logic        loading,
  output logic        load_done,
  output logic        load_err,
  output logic [15:0] load_cksum
);

  import core_pkg::*;

  load_state_t  state, state_nxt;
  load_region_t region;
  load_wr_t     wr_entry, head;
  logic [1:0]   count, count_nxt;
  logic [24:0]  base, size;
  logic         full, start, strobe, in_range, push, pop;
  logic         index_unused;

  // Upper index bits carry no region information.
  assign index_unused = ^ioctl_index[7:6];

  // Base and size of the region latched for the current session.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    base = '0;
    size = '0;
    case (region)
      REGION_ROM: begin base = ROM_BASE_A; size = ROM_SIZE; end
      REGION_RAM: begin base = RAM_BASE_A; size = RAM_SIZE; end
      default: ;
    endcase
  end

  assign mem_req    = (count != 2'd0);
  assign mem_a      = head.a;
  assign mem_d      = head.d;
  assign pop        = mem_ack & mem_req;
  assign start      = (state == LOAD_IDLE) & ioctl_download;
  assign strobe     = (state == LOAD_ACTIVE) & ioctl_wr;
  // Range check on the raw offset, before the base is added.
  assign in_range   = (region != REGION_NONE) & (ioctl_addr < size);
  // A same-cycle pop frees a slot for the incoming strobe.
  assign push       = strobe & in_range & (~full | pop);
  assign wr_entry.a = base + {ioctl_addr[24:1], 1'b0};
  assign wr_entry.d = ioctl_dout;
  assign count_nxt  = count + {1'b0, push} - {1'b0, pop};

  ioctl_loader_fifo u_fifo (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (wr_entry),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full)
  );

  // Session sequencing: start on download high, drain on download low, idle once empty.
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD_IDLE:   if (ioctl_download)    state_nxt = LOAD_ACTIVE;
      LOAD_ACTIVE: if (!ioctl_download)   state_nxt = LOAD_DRAIN;
      LOAD_DRAIN:  if (count_nxt == 2'd0) state_nxt = LOAD_IDLE;
      default:                            state_nxt = LOAD_IDLE;
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= LOAD_IDLE;
    else          state <= state_nxt;
  end

  // Registered status outputs, region latch and sticky error.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ioctl_wait <= 1'b0;
      loading    <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      region     <= REGION_NONE;
    end else begin
      ioctl_wait <= (count_nxt == 2'd2) || (state_nxt == LOAD_DRAIN);
      loading    <= (state_nxt != LOAD_IDLE);
      load_done  <= (state == LOAD_DRAIN) && (state_nxt == LOAD_IDLE);
      if (start) begin
        load_err <= 1'b0;
        region   <= decode_region(ioctl_index[5:0]);
      end else if (strobe && !push) begin
        load_err <= 1'b1;
      end
    end
  end

`ifdef IOCTL_LOADER_CKSUM_EN
  // Running mod-2^16 sum of acknowledged write data, restarted with each session.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)   load_cksum <= '0;
    else if (start) load_cksum <= '0;
    else if (pop)   load_cksum <= load_cksum + mem_d;
  end
`else
  assign load_cksum = 16'h0000;
`endif

endmodule
